// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types: shared types for the LC-3b pipelined core front end.
//
// Contents:
//   ifq_state_t  - instruction-fetch queue FSM states (REQ, UNPACK, DISCARD)
//   ifq_entry_t  - one queued instruction word and its next-PC, packed
//                  {instr, npc}, sized for the default 16-bit word/address
//   sat_inc32    - saturating 32-bit increment used by statistics counters
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    UNPACK  = 2'd1,
    DISCARD = 2'd2
  } ifq_state_t;

  localparam int IFQ_WORD_W = 16;
  localparam int IFQ_ADDR_W = 16;

  typedef struct packed {
    logic [IFQ_WORD_W-1:0] instr;
    logic [IFQ_ADDR_W-1:0] npc;
  } ifq_entry_t;

  // Sticks at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo: synchronous word FIFO with flush for the instruction-fetch queue.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (FIFO empty)
//   flush  in   empties the FIFO; any push/pop in the same cycle is dropped
//   push   in   write din at the tail (honoured when not full, or when a pop
//               happens in the same cycle)
//   din    in   entry to write
//   pop    in   remove the head entry (ignored when empty)
//   dout   out  head entry; driven 0 when empty
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter. dout is read from registered storage only.
// ---------------------------------------------------------------------------
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot index but opposite wrap bits: the writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the head slot, so a full FIFO may still
  // accept a push and keep its occupancy unchanged.
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue: instruction-fetch front end for the pipelined LC-3b core.
//
// Fetches whole lines from instruction memory, unpacks them word by word into
// a DEPTH-entry FIFO and presents the head word to decode. A redirect flushes
// the FIFO and refetches from the new PC; a line response still in flight at
// the time of the redirect is dropped.
//
// Optional build macro: IFQ_STATS_EN adds saturating 32-bit counters
// stat_redirects, stat_discards and stat_empty_cycles.
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   redirect_valid  in   single-cycle redirect request (highest priority)
//   redirect_pc     in   new fetch byte address, bit 0 ignored
//   imem_read       out  line read request, held until imem_resp
//   imem_address    out  line-aligned byte address of the request
//   imem_resp       in   one-cycle response strobe
//   imem_rdata      in   returned line
//   dec_valid       out  head word valid
//   dec_ready       in   decode takes the head word this cycle
//   dec_instr       out  head instruction (0 when empty)
//   dec_npc         out  head instruction address + 2 (0 when empty)
//   dbg_state       out  current FSM state (ifq_state_t encoding)
//   stat_*          out  statistics counters (IFQ_STATS_EN builds only)
//
// Handshakes: a word moves to decode on a rising edge where dec_valid and
// dec_ready are both 1 and no redirect is present; dec_instr/dec_npc stay
// stable while dec_valid is high and dec_ready is low. Memory requests hold
// imem_read and imem_address stable until the cycle imem_resp is seen.
// ---------------------------------------------------------------------------
module ifetch_queue
  import lc3b_types::*;
#(
  parameter int                    LINE_WIDTH = 128,
  parameter int                    WORD_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_read,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic                  imem_resp,
  input  logic [LINE_WIDTH-1:0] imem_rdata,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [WORD_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_npc,
  output logic [1:0]            dbg_state
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]           stat_redirects,
  output logic [31:0]           stat_discards,
  output logic [31:0]           stat_empty_cycles
`endif
);

  localparam int WPL = LINE_WIDTH / WORD_WIDTH;
  localparam int OFF = $clog2(WPL);
  localparam int EW  = WORD_WIDTH + ADDR_WIDTH;
  // Byte-offset bits inside one line: cleared to form the line address.
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << (OFF + 1)) - 1);

  ifq_state_t            state;
  ifq_state_t            state_n;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] fetch_pc_n;
  logic [ADDR_WIDTH-1:0] stale_addr;
  logic [ADDR_WIDTH-1:0] stale_addr_n;
  logic [LINE_WIDTH-1:0] line_buf;
  logic [LINE_WIDTH-1:0] line_buf_n;
  logic                  read_en;

  logic [OFF-1:0]        word_idx;
  logic [WORD_WIDTH-1:0] cur_word;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] pc_plus2;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [ADDR_WIDTH-1:0] redir_pc;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_din;
  logic [EW-1:0]         fifo_dout;

  // -------------------------------------------------------------------------
  // Address arithmetic (modulo 2^ADDR_WIDTH)
  // -------------------------------------------------------------------------
  assign word_idx  = fetch_pc[OFF:1];
  assign last_word = &word_idx;
  assign pc_plus2  = fetch_pc + ADDR_WIDTH'(2);
  assign line_addr = fetch_pc & ~OFF_MASK;
  assign redir_pc  = redirect_pc & ~ADDR_WIDTH'(1);

  // Word selector over the latched line.
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < WPL; k++) begin
      if (word_idx == OFF'(k)) cur_word = line_buf[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= REQ;
      fetch_pc   <= RESET_PC;
      stale_addr <= '0;
      line_buf   <= '0;
      read_en    <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_pc   <= fetch_pc_n;
      stale_addr <= stale_addr_n;
      line_buf   <= line_buf_n;
      read_en    <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state, unpack and redirect handling
  // -------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    stale_addr_n = stale_addr;
    line_buf_n   = line_buf;
    fifo_push    = 1'b0;

    unique case (state)
      REQ: begin
        if (imem_resp) begin
          line_buf_n = imem_rdata;
          state_n    = UNPACK;
        end
      end
      UNPACK: begin
        // A full FIFO still takes a word when decode pops the head.
        if (!fifo_full || dec_ready) begin
          fifo_push  = 1'b1;
          fetch_pc_n = pc_plus2;
          if (last_word) state_n = REQ;
        end
      end
      DISCARD: begin
        // fetch_pc already holds the redirect target; just wait the old
        // response out and then request the new line.
        if (imem_resp) state_n = REQ;
      end
      default: state_n = REQ;
    endcase

    // Redirect overrides everything decided above.
    if (redirect_valid) begin
      fifo_push  = 1'b0;
      line_buf_n = line_buf;
      fetch_pc_n = redir_pc;
      if ((state == REQ || state == DISCARD) && !imem_resp) begin
        state_n = DISCARD;
      end else begin
        state_n = REQ;
      end
      // Keep presenting the outstanding request's address while waiting for
      // its response; later redirects in DISCARD must not disturb it.
      if (state == REQ) stale_addr_n = line_addr;
    end
  end

  assign imem_read    = read_en && (state == REQ || state == DISCARD);
  assign imem_address = (state == DISCARD) ? stale_addr : line_addr;
  assign dbg_state    = state;

  // -------------------------------------------------------------------------
  // Word FIFO
  // -------------------------------------------------------------------------
  assign fifo_din = {cur_word, pc_plus2};
  assign fifo_pop = dec_valid && dec_ready && !redirect_valid;

  ifq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dec_valid = !fifo_empty;
  assign dec_instr = fifo_dout[EW-1:ADDR_WIDTH];
  assign dec_npc   = fifo_dout[ADDR_WIDTH-1:0];

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef IFQ_STATS_EN
  logic resp_dropped;

  // Response that is thrown away: the line was already stale, or a redirect
  // arrived in the same cycle.
  assign resp_dropped = imem_resp && imem_read &&
                        (state == DISCARD || redirect_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_redirects    <= '0;
      stat_discards     <= '0;
      stat_empty_cycles <= '0;
    end else begin
      if (redirect_valid) stat_redirects    <= sat_inc32(stat_redirects);
      if (resp_dropped)   stat_discards     <= sat_inc32(stat_discards);
      if (!dec_valid)     stat_empty_cycles <= sat_inc32(stat_empty_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue: directed self-checking bench for ifetch_queue.
// Memory model: the word at byte address pc holds 16'h1000 + pc/2, so every
// decoded (instr, npc) pair can be computed by hand from its address.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;
  import lc3b_types::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic         redirect_valid = 1'b0;
  logic [15:0]  redirect_pc = '0;
  logic         imem_read;
  logic [15:0]  imem_address;
  logic         imem_resp = 1'b0;
  logic [127:0] imem_rdata = '0;
  logic         dec_valid;
  logic         dec_ready = 1'b0;
  logic [15:0]  dec_instr;
  logic [15:0]  dec_npc;
  logic [1:0]   dbg_state;
`ifdef IFQ_STATS_EN
  logic [31:0]  stat_redirects;
  logic [31:0]  stat_discards;
  logic [31:0]  stat_empty_cycles;
`endif

  // Scoreboard
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  // Memory model controls: initial block sets mem_lat/mem_limit,
  // responder owns mem_served.
  int          mem_lat = 2;
  int          mem_limit = 0;
  int          mem_served = 0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = '0;

  ifetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_npc        (dec_npc),
    .dbg_state      (dbg_state)
`ifdef IFQ_STATS_EN
    ,
    .stat_redirects    (stat_redirects),
    .stat_discards     (stat_discards),
    .stat_empty_cycles (stat_empty_cycles)
`endif
  );

  function automatic logic [127:0] mk_line(input logic [15:0] a);
    logic [127:0] l;
    logic [15:0]  base;
    base = 16'h1000 + (a >> 1);
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = base + 16'(k);
    return l;
  endfunction

  // Memory responder: latches the address when a request is seen, answers
  // mem_lat falling edges later with a one-cycle imem_resp.
  always @(negedge clk) begin
    imem_resp = 1'b0;
    if (!rst_n) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = mk_line(mem_addr);
        mem_busy   = 1'b0;
        mem_served = mem_served + 1;
      end
    end else if (imem_read && mem_served < mem_limit) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_address;
    end
  end

  // Driver / checker tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input logic [15:0] start, input int n);
    logic [15:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 16'(2 * i);
      exp_q.push_back({16'h1000 + (pc >> 1), pc + 16'd2});
    end
  endtask

  // Checks the handshake about to happen on the next rising edge, then
  // advances to just after the following falling edge.
  task automatic step();
    logic [31:0] e;
    if (rst_n && dec_valid && dec_ready && !redirect_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_word observed=%h expected=none", {dec_instr, dec_npc});
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dec_word", {dec_instr, dec_npc}, e);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (dbg_state !== s && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(dbg_state), 32'(s));
  endtask

  initial begin
    int n;

    // ---- Reset values -------------------------------------------------
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", 32'(dec_instr), 32'd0);
    chk("rst_dec_npc",   32'(dec_npc),   32'd0);
    chk("rst_imem_read", 32'(imem_read), 32'd0);
    chk("rst_state",     32'(dbg_state), 32'(REQ));

    // ---- T1: first line, decode always ready ---------------------------
    mem_lat   = 2;
    mem_limit = 1;
    dec_ready = 1'b1;
    rst_n     = 1'b1;
    push_words(16'h0000, 8);
    step();
    chk("t1_first_read", 32'(imem_read),    32'd1);
    chk("t1_first_addr", 32'(imem_address), 32'h0000);
    drain(60, "t1_drain");
    chk("t1_next_read", 32'(imem_read),    32'd1);
    chk("t1_next_addr", 32'(imem_address), 32'h0010);
    chk("t1_state",     32'(dbg_state),    32'(REQ));

    // ---- T2: decode stalled, FIFO fills, then full push+pop -----------
    dec_ready = 1'b0;
    mem_limit = 2;
    repeat (16) step();
    chk("t2_stall_state", 32'(dbg_state), 32'(UNPACK));
    chk("t2_stall_valid", 32'(dec_valid), 32'd1);
    chk("t2_stall_instr", 32'(dec_instr), 32'h1008);
    chk("t2_stall_npc",   32'(dec_npc),   32'h0012);
    chk("t2_stall_read",  32'(imem_read), 32'd0);
    push_words(16'h0010, 8);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    repeat (3) step();
    chk("t2_head_instr", 32'(dec_instr), 32'h1009);
    chk("t2_head_npc",   32'(dec_npc),   32'h0014);
    chk("t2_still_unpack", 32'(dbg_state), 32'(UNPACK));
    dec_ready = 1'b1;
    drain(60, "t2_drain");
    chk("t2_next_addr", 32'(imem_address), 32'h0020);

    // ---- T3: redirect to mid-line address while unpacking -------------
    dec_ready = 1'b0;
    mem_limit = 3;
    wait_state(2'(UNPACK), 20, "t3_reach_unpack");
    repeat (3) step();
    chk("t3_pre_valid", 32'(dec_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0037;  // bit 0 must be ignored
    step();
    redirect_valid = 1'b0;
    chk("t3_flushed",  32'(dec_valid),    32'd0);
    chk("t3_state",    32'(dbg_state),    32'(REQ));
    chk("t3_req_read", 32'(imem_read),    32'd1);
    chk("t3_req_addr", 32'(imem_address), 32'h0030);
    mem_limit = 4;
    dec_ready = 1'b1;
    push_words(16'h0036, 5);
    drain(60, "t3_drain");
    chk("t3_next_addr", 32'(imem_address), 32'h0040);

    // ---- T4: redirect while a request is outstanding ------------------
    mem_lat   = 5;
    mem_limit = 6;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0050;
    step();
    redirect_valid = 1'b0;
    chk("t4_state", 32'(dbg_state),    32'(DISCARD));
    chk("t4_read",  32'(imem_read),    32'd1);
    chk("t4_addr",  32'(imem_address), 32'h0040);
    push_words(16'h0050, 8);
    drain(80, "t4_drain");
    chk("t4_next_addr", 32'(imem_address), 32'h0060);

    // ---- T5: redirect on imem_resp, then redirects around DISCARD -----
    mem_lat   = 4;
    mem_limit = 9;
    n = 0;
    while (!imem_resp && n < 20) begin
      step();
      n++;
    end
    chk("t5_resp_seen", 32'(imem_resp), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0070;
    step();
    redirect_valid = 1'b0;
    chk("t5_coinc_state", 32'(dbg_state),    32'(REQ));
    chk("t5_coinc_addr",  32'(imem_address), 32'h0070);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    step();
    redirect_valid = 1'b0;
    chk("t5_disc_state", 32'(dbg_state),    32'(DISCARD));
    chk("t5_disc_addr",  32'(imem_address), 32'h0070);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h00A4;
    step();
    redirect_valid = 1'b0;
    chk("t5_disc2_state", 32'(dbg_state),    32'(DISCARD));
    chk("t5_disc2_addr",  32'(imem_address), 32'h0070);
    push_words(16'h00A4, 6);
    drain(80, "t5_drain");
    chk("t5_next_addr", 32'(imem_address), 32'h00B0);
`ifdef IFQ_STATS_EN
    chk("t5_stat_redirects", stat_redirects, 32'd5);
    chk("t5_stat_discards",  stat_discards,  32'd3);
`endif

    // ---- T6: asynchronous reset mid-UNPACK ----------------------------
    mem_lat   = 1;
    mem_limit = 10;
    dec_ready = 1'b0;
    n = 0;
    while (!(dbg_state == 2'(UNPACK) && dec_valid) && n < 20) begin
      step();
      n++;
    end
    chk("t6_pre_valid", 32'(dec_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(dec_valid), 32'd0);
    chk("t6_async_instr", 32'(dec_instr), 32'd0);
    chk("t6_async_npc",   32'(dec_npc),   32'd0);
    chk("t6_async_read",  32'(imem_read), 32'd0);
    chk("t6_async_state", 32'(dbg_state), 32'(REQ));
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    mem_limit = 11;
    dec_ready = 1'b1;
    push_words(16'h0000, 8);
    step();
    chk("t6_refetch_read", 32'(imem_read),    32'd1);
    chk("t6_refetch_addr", 32'(imem_address), 32'h0000);
    drain(60, "t6_drain");
    chk("t6_next_addr", 32'(imem_address), 32'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Parametrised instruction-fetch front end for the pipelined LC-3b core.
- Requests full lines from instruction memory and unpacks them into words.
- Buffers the words in a DEPTH-entry word FIFO and presents them to decode with a valid/ready handshake.
- On a branch/jump redirect, flushes the FIFO and refetches from the new PC, dropping any response still in flight.

Parameters:
LINE_WIDTH, 128, memory line width in bits; must be a power-of-two multiple of WORD_WIDTH
WORD_WIDTH, 16, instruction width in bits
ADDR_WIDTH, 16, byte-address width
DEPTH, 4, word-FIFO entries; power of two, >= 2
RESET_PC, 16'h0000, fetch PC after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  single-cycle redirect request
redirect_pc  in  ADDR_WIDTH  new fetch byte address; bit 0 ignored
imem_read  out  1  line read request; held high until imem_resp
imem_address  out  ADDR_WIDTH  line-aligned byte address
imem_resp  in  1  read data valid, one cycle
imem_rdata  in  LINE_WIDTH  returned line
dec_valid  out  1  dec_instr/dec_npc valid
dec_ready  in  1  decode accepts the head word this cycle
dec_instr  out  WORD_WIDTH  head instruction
dec_npc  out  ADDR_WIDTH  head instruction address + 2

Behaviour:
- Derived values: WPL = LINE_WIDTH/WORD_WIDTH; OFF = log2(WPL).
- Word index = pc[OFF:1].
- imem_address = fetch_pc with bits [OFF:0] cleared.
- Word k of a line = imem_rdata[k*WORD_WIDTH +: WORD_WIDTH].
- Reset (asynchronous, active-low):
  - state=REQ, fetch_pc=RESET_PC.
  - FIFO empty, line buffer invalid.
  - Outputs: dec_valid=0, dec_instr=0, dec_npc=0, imem_read=0.
  - imem_read asserts in the first cycle after rst_n deasserts.
- FSM states REQ, UNPACK, DISCARD:
  - REQ: imem_read=1. On imem_resp, latch the line and go to UNPACK.
  - UNPACK: imem_read=0.
    - Each cycle the FIFO is not full, or is full with dec_ready=1, push word[fetch_pc[OFF:1]] with npc=fetch_pc+2, then fetch_pc += 2.
    - A push of the last word of the line (index WPL-1) returns to REQ; fetch_pc wraps into the next line.
  - DISCARD: imem_read=1 with the stale address until imem_resp. Drop the data, then go to REQ with the redirect PC.
- Redirect priority is highest. In every state, redirect_valid=1:
  - empties the FIFO and cancels any push or pop that cycle;
  - sets fetch_pc={redirect_pc[ADDR_WIDTH-1:1],1'b0}.
  - Next state: DISCARD if in REQ without imem_resp this cycle, else REQ.
  - imem_resp coinciding with a redirect is dropped and the next state is REQ.
- A redirect during DISCARD overwrites the pending PC; the FSM stays in DISCARD.
- FIFO:
  - Pointer width log2(DEPTH)+1, with wrap bit.
  - Full when the pointers differ only in the MSB.
  - Pop when dec_valid & dec_ready.
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - Push into an empty FIFO is visible on dec_valid the next cycle. There is no combinational memory-to-decode path.
- dec_valid = !empty.
  - dec_instr/dec_npc hold their value while dec_valid & !dec_ready.
  - When empty they are driven 0.
- Redirect to a mid-line address: the unpack starts at that word index. Earlier words in the line are never pushed.
- fetch_pc arithmetic is modulo 2^ADDR_WIDTH; 16'hFFFE+2 wraps to 16'h0000.

Optional Feature:
IFQ_STATS_EN:
- Defined: adds 32-bit saturating outputs stat_redirects, stat_discards and stat_empty_cycles.
  - stat_discards counts responses dropped in DISCARD or coincident with a redirect.
  - stat_empty_cycles counts cycles with dec_valid=0 after reset.
  - All reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Add to lc3b_types:
  - ifq_state_t enum {REQ, UNPACK, DISCARD};
  - a packed ifq_entry_t {instr, npc} struct.
- One sub-module, ifq_fifo: parametrised synchronous FIFO with flush, push, pop, full and empty; async active-low reset.
- FSM and unpack logic stay in ifetch_queue.

Test Plan:
- Reset, memory returns line words 0x1000..0x1007 at address 0x0000, dec_ready=1 -> decode sees 0x1000..0x1007 with npc 0x0002..0x0010; the next imem_address is 0x0010.
- dec_ready=0, DEPTH=4 -> exactly 4 words are buffered and the FSM stalls in UNPACK. Raising dec_ready -> in-order drain with no drop or duplicate.
- Redirect to 0x0036 while in UNPACK -> FIFO flushed; next request to 0x0030; first decoded word is index 3 with npc 0x0038.
- Redirect while a REQ is outstanding, response after 5 cycles -> that line is dropped; a new request to the redirect line follows; no stale word reaches decode.
- Redirect in the same cycle as imem_resp, then a second redirect during DISCARD -> last redirect PC wins; stat_discards increments under IFQ_STATS_EN.
- rst_n asserted mid-UNPACK with dec_valid=1 -> dec_valid=0 immediately (asynchronous); refetch starts from RESET_PC after release.
